// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one uart_tx among NUM_REQ requesters
// Optional watchdog abort enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               last_q, last_d;
    logic               done_q;
    logic [IW-1:0]      win_idx;
    logic               win_found;
    logic               abort;
    logic               wd_expired;

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] idx);
        if (idx == IW'(NUM_REQ - 1))
            return '0;
        return idx + IW'(1);
    endfunction

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin : rr_search
        logic [IW:0] cand;
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= NR)
                cand = cand - NR;
            if (!win_found && i_Req_Valid[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        wd_count;

    assign wd_count   = ((state_q == LAUNCH) && !i_Req_Valid[gidx_q]) || (state_q == WAIT_DONE);
    assign wd_expired = wd_count && (wd_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            wd_q <= '0;
        else if (state_d != state_q)
            wd_q <= '0;
        else if (wd_count)
            wd_q <= wd_q + 16'd1;
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign wd_expired            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        o_Tx_DV     = 1'b0;
        o_Req_Ready = '0;
        o_Tx_Byte   = '0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found && !i_Tx_Active) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                    state_d          = LAUNCH;
                end
            end
            LAUNCH: begin
                // A frame still finishing in uart_tx (e.g. after reset) holds the launch off.
                if (i_Req_Valid[gidx_q] && !i_Tx_Active && !i_Tx_Done && !i_Reset) begin
                    o_Tx_DV             = 1'b1;
                    o_Req_Ready[gidx_q] = 1'b1;
                    o_Tx_Byte           = i_Req_Byte[{gidx_q, 3'b000} +: 8];
                    last_d              = i_Req_Last[gidx_q];
                    state_d             = WAIT_DONE;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (i_Tx_Done && !done_q)
                    state_d = DRAIN;
                else if (wd_expired)
                    abort = 1'b1;
            end
            DRAIN: begin
                if (!i_Tx_Done && !i_Tx_Active) begin
                    if (!last_q) begin
                        state_d = LAUNCH;
                    end else begin
                        // After an abort the grant is already gone and the pointer already moved.
                        if (|grant_q)
                            ptr_d = inc_idx(gidx_q);
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            grant_d = '0;
            ptr_d   = inc_idx(gidx_q);
            last_d  = 1'b1;
            state_d = DRAIN;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            done_q  <= i_Tx_Done;
        end
    end

    assign o_Grant   = grant_q;
    assign o_Busy    = (state_q != IDLE);
    assign o_Timeout = abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a packet-level round-robin model
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_byte;
    logic           tx_dv, tx_active, tx_done, busy, timeout;
    logic [7:0]     tx_byte;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(100)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ready (req_ready),
        .o_Grant     (grant),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Busy      (busy),
        .o_Timeout   (timeout)
    );

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    logic [8:0] rq[N][$];   // {last, byte} per requester
    exp_t       expq[$];
    int         errors = 0, checks = 0;
    int         mp = 0;     // model round-robin pointer
    int         act_left = 0, done_left = 0;
    logic       launched = 1'b0;
    int         dv_count = 0, to_count = 0, first_dv = -1, cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Whole packets go out in round-robin order among requesters with pending packets.
    task automatic build_expected();
        int   pos[N];
        int   k;
        logic [8:0] e;
        logic done;
        for (int i = 0; i < N; i++) pos[i] = 0;
        forever begin
            k = -1;
            for (int i = 0; i < N; i++)
                if (k < 0 && pos[(mp + i) % N] < rq[(mp + i) % N].size()) k = (mp + i) % N;
            if (k < 0) break;
            done = 1'b0;
            while (!done && pos[k] < rq[k].size()) begin
                e = rq[k][pos[k]];
                pos[k]++;
                expq.push_back('{k, e[7:0]});
                done = e[8];
            end
            mp = (k + 1) % N;
        end
    endtask

    task automatic step();
        exp_t ex;
        @(posedge clk);
        #1;
        if (launched) begin
            act_left = $urandom_range(2, 6);
            launched = 1'b0;
        end else if (act_left > 0) begin
            act_left--;
            if (act_left == 0) done_left = $urandom_range(1, 3);
        end else if (done_left > 0) begin
            done_left--;
        end
        tx_active = (act_left > 0);
        tx_done   = (done_left > 0);
        for (int k = 0; k < N; k++) begin
            req_valid[k]       = (rq[k].size() > 0);
            req_last[k]        = (rq[k].size() > 0) ? rq[k][0][8] : 1'b0;
            req_byte[8*k +: 8] = (rq[k].size() > 0) ? rq[k][0][7:0] : 8'h00;
        end
        #1;
        cyc++;
        if (timeout) to_count++;
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        if (tx_dv) begin
            dv_count++;
            if (first_dv < 0) first_dv = cyc;
            check("dv_line_idle", 32'({tx_active, tx_done}), 32'd0);
            check("dv_pending", 32'(expq.size() > 0), 32'd1);
            if (expq.size() > 0) begin
                ex = expq.pop_front();
                check("dv_grant", 32'(grant), 32'(1 << ex.req));
                check("dv_byte", 32'(tx_byte), 32'(ex.data));
            end
            check("ready_eq_grant", 32'(req_ready), 32'(grant));
            for (int k = 0; k < N; k++)
                if (req_ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            launched = 1'b1;
        end else begin
            check("ready_idle", 32'(req_ready), 32'd0);
        end
    endtask

    task automatic run(input int budget);
        first_dv = -1;
        cyc      = 0;
        dv_count = 0;
        do step(); while ((expq.size() > 0 || busy || tx_active || tx_done) && cyc < budget);
        check("run_finished", 32'(expq.size()), 32'd0);
        check("idle_after", 32'({busy, grant}), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({grant, req_ready, tx_dv, tx_byte, busy, timeout}), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = '0; req_last = '0; req_byte = '0;
        tx_active = 1'b0; tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;

        // Single request from requester 2, then probe the pointer is 3.
        rq[2].push_back({1'b1, 8'hA5});
        build_expected();
        run(200);
        check("single_dv_count", 32'(dv_count), 32'd1);
        check("single_latency", 32'(first_dv), 32'd2);
        rq[0].push_back({1'b1, 8'h01});
        rq[3].push_back({1'b1, 8'h03});
        build_expected();
        check("ptr3_first", 32'(expq[0].req), 32'd3);
        run(400);

        // Contention after reset: order 0,1,2,3,0.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; mp = 0;
        rq[0].push_back({1'b1, 8'hC0}); rq[0].push_back({1'b1, 8'hC4});
        rq[1].push_back({1'b1, 8'hC1});
        rq[2].push_back({1'b1, 8'hC2});
        rq[3].push_back({1'b1, 8'hC3});
        build_expected();
        run(800);
        check("contention_dv_count", 32'(dv_count), 32'd5);

        // Packet lock: requester 1 sends three bytes while requester 0 waits.
        rq[1].push_back({1'b0, 8'h10}); rq[1].push_back({1'b0, 8'h11}); rq[1].push_back({1'b1, 8'h12});
        rq[0].push_back({1'b1, 8'h55});
        build_expected();
        check("lock_order", 32'({expq[2].req[1:0], expq[3].req[1:0]}), 32'h4);
        run(800);

        // Reset during WAIT_DONE with a frame in flight.
        rq[0].push_back({1'b1, 8'h3C});
        build_expected();
        n = 0;
        do begin step(); n++; end while (!launched && n < 20);
        check("rst_test_launched", 32'(launched), 32'd1);
        step();
        check("rst_test_active", 32'(tx_active), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mp = 0;
        check_all_zero("rst_mid_outputs");
        rq[3].push_back({1'b1, 8'h77});
        build_expected();
        run(400);

        // Randomized packet sets, pointer carried over between rounds.
        for (int r = 0; r < 6; r++) begin
            n = 0;
            for (int k = 0; k < N; k++) begin
                int npk, len;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        rq[k].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                        n++;
                    end
                end
            end
            if (n == 0) rq[r % N].push_back({1'b1, 8'($urandom)});
            build_expected();
            run(3000);
        end
        check("no_timeout_pulse", 32'(to_count), 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Requester 0 drops valid mid-packet; watchdog aborts and requester 1 follows.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; mp = 0;
        rq[0].push_back({1'b0, 8'h21});
        rq[1].push_back({1'b1, 8'h31});
        expq.push_back('{0, 8'h21});
        expq.push_back('{1, 8'h31});
        mp = 2;
        to_count = 0;
        run(1000);
        check("timeout_pulses", 32'(to_count), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
